// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types, widths and helpers for the multi-channel clock divider
package clk_div_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Lock counter is sized for the largest legal LOCK_CYCLES so any override fits.
    localparam int LOCK_CYCLES_MAX = 255;
    localparam int LOCK_W          = $clog2(LOCK_CYCLES_MAX + 1);

    function automatic int period_cycles(input int d);
        return 2 * (d + 1);
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - control and status bundle between a controller and clk_div_multi
interface clk_div_multi_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       div_ack;
    logic [NUM_CH-1:0]       clock_out;
    logic [NUM_CH-1:0]       tick_rise;
    logic [NUM_CH-1:0]       tick_fall;
    logic [NUM_CH-1:0]       locked;

    modport master (
        output enable, div_in, div_load,
        input  div_ack, clock_out, tick_rise, tick_fall, locked
    );

    modport slave (
        input  enable, div_in, div_load,
        output div_ack, clock_out, tick_rise, tick_fall, locked
    );
endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divided-clock channel: FSM, phase counter, pending divisor, lock counter
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_RESET   = 0,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             clock_in,
    input  logic             resetb,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             clock_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             locked
);

    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
    localparam logic [DIV_W-1:0]  D_RST    = DIV_W'(DIV_RESET);

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   cnt, cnt_nxt;
    logic [DIV_W-1:0]   d_act, d_act_nxt;
    logic [DIV_W-1:0]   d_pend, d_pend_nxt;
    logic               pend, pend_nxt;
    logic [LOCK_W-1:0]  lock_cnt, lock_nxt;
    logic               clk_nxt, rise_nxt, fall_nxt, ack_nxt;
    logic               at_end, falling, apply;

    assign at_end  = (cnt == d_act);
    // A high-to-low toggle is the only point a running channel may change divisor.
    assign falling = (state != OFF) && clock_out && at_end;
    assign apply   = pend && ((state == OFF) || falling);
    assign locked  = (lock_cnt == LOCK_MAX);

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state     <= OFF;
            cnt       <= '0;
            d_act     <= D_RST;
            d_pend    <= '0;
            pend      <= 1'b0;
            lock_cnt  <= '0;
            clock_out <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            div_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            d_act     <= d_act_nxt;
            d_pend    <= d_pend_nxt;
            pend      <= pend_nxt;
            lock_cnt  <= lock_nxt;
            clock_out <= clk_nxt;
            tick_rise <= rise_nxt;
            tick_fall <= fall_nxt;
            div_ack   <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (!enable) begin
                    if (!clock_out || at_end) state_nxt = OFF;
                    else                      state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (enable)      state_nxt = RUN;
                else if (at_end) state_nxt = OFF;
            end
            default: state_nxt = OFF;
        endcase
    end

    always_comb begin
        cnt_nxt    = cnt;
        d_act_nxt  = d_act;
        d_pend_nxt = d_pend;
        pend_nxt   = pend;
        lock_nxt   = lock_cnt;
        clk_nxt    = clock_out;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        ack_nxt    = 1'b0;

        if (apply) begin
            d_act_nxt = d_pend;
            pend_nxt  = 1'b0;
            ack_nxt   = 1'b1;
        end
        // A load coinciding with a boundary lands after the apply, so it waits for the next one.
        if (div_load) begin
            d_pend_nxt = div_in;
            pend_nxt   = 1'b1;
        end

        if (state_nxt == OFF) begin
            cnt_nxt  = '0;
            clk_nxt  = 1'b0;
            fall_nxt = falling;
            lock_nxt = '0;
        end else if (state == OFF) begin
            cnt_nxt = '0;
        end else if (at_end) begin
            cnt_nxt  = '0;
            clk_nxt  = !clock_out;
            rise_nxt = !clock_out;
            fall_nxt = clock_out;
            if (!clock_out && (lock_cnt != LOCK_MAX))
                lock_nxt = lock_cnt + LOCK_W'(1);
        end else begin
            cnt_nxt = cnt + DIV_W'(1);
        end

        if ((state_nxt == STOPPING) || apply)
            lock_nxt = '0;
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent programmable 50%-duty clock dividers
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_RESET   = 0,
    parameter int LOCK_CYCLES = 16
) (
    input  logic            clock_in,
    input  logic            resetb,
    clk_div_multi_if.slave  bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W       (DIV_W),
            .DIV_RESET   (DIV_RESET),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_chan (
            .clock_in  (clock_in),
            .resetb    (resetb),
            .enable    (bus.enable[i]),
            .div_in    (bus.div_in[i*DIV_W +: DIV_W]),
            .div_load  (bus.div_load[i]),
            .div_ack   (bus.div_ack[i]),
            .clock_out (bus.clock_out[i]),
            .tick_rise (bus.tick_rise[i]),
            .tick_fall (bus.tick_fall[i]),
            .locked    (bus.locked[i])
        );
    end

endmodule
